// File: rtl/fft_bf_sched.sv
// Frame-level sequencer for an 8-point radix-2 butterfly datapath: accepts frames, issues pair
// indices, tracks them through the fixed datapath latency and hands finished frames downstream.
module fft_bf_sched #(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned PAIRS   = 4,
  parameter int unsigned IDX_W   = $clog2(PAIRS),
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             load_en_o,
  output logic             bf_idx_valid_o,
  output logic [IDX_W-1:0] bf_idx_o,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_HOLD
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [LATENCY-1:0]          dl_valid_q;
  logic [LATENCY-1:0][IDX_W-1:0] dl_idx_q;
  logic [CNT_W-1:0]            frame_cnt_q;
  logic                        out_hs;
  logic                        last_issue;
  logic                        last_wr;

  // Outputs decoded straight from state; in_ready_o sees out_ready_i combinationally so a
  // completed frame can be handed off and the next one loaded in the same cycle.
  assign out_valid_o    = (state_q == S_HOLD);
  assign busy_o         = (state_q != S_IDLE);
  assign bf_idx_valid_o = (state_q == S_ISSUE);
  assign bf_idx_o       = bf_idx_valid_o ? idx_q : '0;
  assign in_ready_o     = rst_ni & ~flush_i &
                          ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready_i));
  assign load_en_o      = in_valid_i & in_ready_o;
  assign out_hs         = out_valid_o & out_ready_i & ~flush_i;
  assign wr_en_o        = dl_valid_q[LATENCY-1];
  assign wr_idx_o       = dl_idx_q[LATENCY-1];
  assign frame_cnt_o    = frame_cnt_q;
  assign last_issue     = (idx_q == LAST_IDX);
  assign last_wr        = wr_en_o & (wr_idx_o == LAST_IDX);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_en_o) begin
            state_d = S_ISSUE;
            idx_d   = '0;
          end
        end
        S_ISSUE: begin
          if (last_issue) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (last_wr) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (out_ready_i) begin
            state_d = load_en_o ? S_ISSUE : S_IDLE;
            idx_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (out_hs) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the delay line is a small register array, not a RAM, so it is reset: stale valids
  // must never produce a write strobe after reset. Flush clears valids only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_valid_q <= '0;
      dl_idx_q   <= '0;
    end else begin
      dl_valid_q[0] <= bf_idx_valid_o & ~flush_i;
      dl_idx_q[0]   <= bf_idx_o;
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1] & ~flush_i;
        dl_idx_q[i]   <= dl_idx_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_bf_sched.sv
// Randomised scoreboard bench for fft_bf_sched: a frame-timeline reference model pushes expected
// per-cycle outputs, issues and write-backs; a negedge monitor pops and compares them.
module tb_fft_bf_sched;

  localparam int LATENCY = 5;
  localparam int PAIRS   = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 2;

  typedef struct {
    int t;
    int idx;
  } ev_t;

  typedef struct {
    int t;
    bit in_ready;
    bit load_en;
    bit busy;
    bit out_valid;
    int cnt;
  } cyc_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic             load_en_o;
  logic             bf_idx_valid_o;
  logic [IDX_W-1:0] bf_idx_o;
  logic             wr_en_o;
  logic [IDX_W-1:0] wr_idx_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic             busy_o;
  logic [CNT_W-1:0] frame_cnt_o;

  fft_bf_sched #(
    .LATENCY(LATENCY),
    .PAIRS  (PAIRS),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .load_en_o     (load_en_o),
    .bf_idx_valid_o(bf_idx_valid_o),
    .bf_idx_o      (bf_idx_o),
    .wr_en_o       (wr_en_o),
    .wr_idx_o      (wr_idx_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  ev_t  issue_q[$];
  ev_t  wr_q[$];
  cyc_t cyc_q[$];

  // Reference model: a frame is just its accept cycle; everything else follows from it.
  bit               active = 1'b0;
  int               acc_t = 0;
  logic [CNT_W-1:0] frame_cnt_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic report(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s @cycle %0d: %s", name, cyc, what);
  endtask

  task automatic step(input bit iv, input bit ordy, input bit fl);
    int   n;
    bit   ov;
    bit   ir;
    bit   acc_now;
    cyc_t r;
    ev_t  e;
    @(posedge clk_i);
    #1;
    in_valid_i  = iv;
    out_ready_i = ordy;
    flush_i     = fl;
    n       = cyc;
    ov      = active && (n >= acc_t + PAIRS + LATENCY + 1);
    ir      = !fl && (!active || (ov && ordy));
    acc_now = iv && ir;
    r.t = n; r.in_ready = ir; r.load_en = acc_now; r.busy = active; r.out_valid = ov;
    r.cnt = int'(frame_cnt_m);
    cyc_q.push_back(r);
    if (active && n >= acc_t + 1 && n <= acc_t + PAIRS) begin
      e.t = n; e.idx = n - acc_t - 1;
      issue_q.push_back(e);
      if (!fl) begin
        e.t = n + LATENCY;
        wr_q.push_back(e);
      end
    end
    if (fl) begin
      while (wr_q.size() > 0 && wr_q[$].t > n) void'(wr_q.pop_back());
      active = 1'b0;
    end else if (ov && ordy) begin
      frame_cnt_m++;
      active = acc_now;
      acc_t  = n;
    end else if (acc_now) begin
      active = 1'b1;
      acc_t  = n;
    end
    mon_en = 1'b1;
  endtask

  task automatic reset_pulse();
    @(posedge clk_i);
    #1;
    mon_en     = 1'b0;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    rst_ni     = 1'b0;
    #1;
    check("rst_wr_en", wr_en_o, 0);
    check("rst_bf_idx_valid", bf_idx_valid_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_frame_cnt", frame_cnt_o, 0);
    check("rst_load_en", load_en_o, 0);
    #1;
    rst_ni = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready_o, 1);
    active      = 1'b0;
    frame_cnt_m = '0;
    issue_q.delete();
    wr_q.delete();
    cyc_q.delete();
  endtask

  always @(negedge clk_i) begin
    cyc_t r;
    ev_t  e;
    if (mon_en) begin
      if (cyc_q.size() == 0) report("cycle_record", "no expected record");
      else begin
        r = cyc_q.pop_front();
        check("in_ready_o", in_ready_o, r.in_ready);
        check("load_en_o", load_en_o, r.load_en);
        check("busy_o", busy_o, r.busy);
        check("out_valid_o", out_valid_o, r.out_valid);
        check("frame_cnt_o", frame_cnt_o, r.cnt);
      end
      if (bf_idx_valid_o) begin
        if (issue_q.size() == 0) report("bf_idx_spurious", "bf_idx_valid_o=1, expected none");
        else begin
          e = issue_q.pop_front();
          check("bf_idx_cycle", cyc, e.t);
          check("bf_idx_o", bf_idx_o, e.idx);
        end
      end else begin
        check("bf_idx_o_idle", bf_idx_o, 0);
        if (issue_q.size() > 0 && issue_q[0].t <= cyc) begin
          e = issue_q.pop_front();
          report("bf_idx_missing", $sformatf("bf_idx_valid_o=0, expected idx %0d", e.idx));
        end
      end
      if (wr_en_o) begin
        if (wr_q.size() == 0) report("wr_en_spurious", "wr_en_o=1, expected none");
        else begin
          e = wr_q.pop_front();
          check("wr_en_cycle", cyc, e.t);
          check("wr_idx_o", wr_idx_o, e.idx);
        end
      end else if (wr_q.size() > 0 && wr_q[0].t <= cyc) begin
        e = wr_q.pop_front();
        report("wr_en_missing", $sformatf("wr_en_o=0, expected idx %0d", e.idx));
      end
    end
  end

  initial begin
    #2;
    check("reset_busy", busy_o, 0);
    check("reset_out_valid", out_valid_o, 0);
    check("reset_wr_en", wr_en_o, 0);
    check("reset_bf_idx_valid", bf_idx_valid_o, 0);
    check("reset_frame_cnt", frame_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    check("reset_in_ready", in_ready_o, 1);

    // Single frame, downstream always ready.
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);

    // Backpressure: frame held for 20+ cycles while upstream keeps offering.
    step(1, 0, 0);
    repeat (30) step(1, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 1, 0);

    // Back-to-back frames with counter wrap.
    repeat (55) step(1, 1, 0);
    step(0, 1, 1);

    // Flush in ISSUE while idx 1 is presented.
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (10) step(0, 1, 0);

    // Async reset pulse during DRAIN, then a clean frame.
    step(1, 1, 0);
    repeat (6) step(0, 1, 0);
    reset_pulse();
    step(1, 1, 0);
    repeat (12) step(0, 1, 0);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);

    repeat (20) step(0, 1, 0);
    @(negedge clk_i);
    #1;
    check("issue_q_drained", issue_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("cyc_q_drained", cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
